// File: rtl/dram_arbiter.sv
// Round-robin arbiter giving NCORES cores and a host preload port access to one shared RAM.
// Optional access counter port accCount is built when DRAM_ARB_STATS_EN is defined.
module dram_arbiter #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NCORES = 4
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [NCORES-1:0]       memREAD,
  input  logic [NCORES-1:0]       memWRITE,
  input  logic [NCORES*WIDTH-1:0] coreAddr,
  input  logic [NCORES*WIDTH-1:0] coreWData,
  output logic [WIDTH-1:0]        rdData,
  output logic [NCORES-1:0]       memAV,
  input  logic                    extWE,
  input  logic [WIDTH-1:0]        extAddr,
  input  logic [WIDTH-1:0]        extData,
  output logic                    extAck,
  output logic                    busy,
  output logic                    protoErr
`ifdef DRAM_ARB_STATS_EN
  ,
  output logic [15:0]             accCount
`endif
);

  localparam int unsigned IdxW  = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int unsigned Depth = 2 ** WIDTH;

  typedef enum logic [1:0] {StIdle, StServe, StDone} state_e;

  state_e            state_q;
  logic [IdxW-1:0]   rr_ptr_q;
  logic [IdxW-1:0]   core_q;
  logic              op_wr_q;
  logic [WIDTH-1:0]  addr_q;
  logic [WIDTH-1:0]  wdata_q;
  logic [NCORES-1:0] need_drop_q;
  logic [NCORES-1:0] need_drop_d;
  logic [WIDTH-1:0]  mem_q [Depth];

  logic [NCORES-1:0] eligible;
  logic              grant_valid;
  logic [IdxW-1:0]   grant_idx;
  logic [IdxW-1:0]   cand;
  logic              ram_we;
  logic [WIDTH-1:0]  ram_waddr;
  logic [WIDTH-1:0]  ram_wdata;

  assign eligible = (memREAD | memWRITE) & ~need_drop_q;

  // First eligible core at or above rr_ptr_q, wrapping around.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NCORES; i++) begin
      cand = IdxW'((32'(rr_ptr_q) + i) % NCORES);
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // A served request stays blocked until the core drops both request lines.
  always_comb begin
    need_drop_d = need_drop_q;
    if (state_q == StDone) need_drop_d[core_q] = 1'b1;
    need_drop_d = need_drop_d & (memREAD | memWRITE);
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = addr_q;
    ram_wdata = wdata_q;
    if (!Rst) begin
      if (state_q == StIdle && extWE) begin
        ram_we    = 1'b1;
        ram_waddr = extAddr;
        ram_wdata = extData;
      end else if (state_q == StServe && op_wr_q) begin
        ram_we = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (ram_we) mem_q[ram_waddr] <= ram_wdata;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      core_q      <= '0;
      op_wr_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      need_drop_q <= '0;
      rdData      <= '0;
      memAV       <= '0;
      extAck      <= 1'b0;
      busy        <= 1'b0;
      protoErr    <= 1'b0;
`ifdef DRAM_ARB_STATS_EN
      accCount    <= '0;
`endif
    end else begin
      memAV       <= '0;
      extAck      <= 1'b0;
      need_drop_q <= need_drop_d;
      protoErr    <= protoErr | (|(memREAD & memWRITE));
      unique case (state_q)
        StIdle: begin
          if (extWE) begin
            extAck <= 1'b1;
          end else if (grant_valid) begin
            core_q  <= grant_idx;
            // Write wins when both lines are high.
            op_wr_q <= memWRITE[grant_idx];
            addr_q  <= coreAddr[32'(grant_idx) * WIDTH +: WIDTH];
            wdata_q <= coreWData[32'(grant_idx) * WIDTH +: WIDTH];
            state_q <= StServe;
            busy    <= 1'b1;
          end
        end
        StServe: begin
          if (!op_wr_q) rdData <= mem_q[addr_q];
          memAV   <= NCORES'(1) << core_q;
          state_q <= StDone;
`ifdef DRAM_ARB_STATS_EN
          if (accCount != 16'hFFFF) accCount <= accCount + 16'd1;
`endif
        end
        StDone: begin
          rr_ptr_q <= (32'(core_q) == NCORES - 1) ? '0 : core_q + 1'b1;
          state_q  <= StIdle;
          busy     <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Shared data-memory responder on the far side of the per-core DRAM request interface (`memREAD`/`memWRITE`/`DRAM_addr`/`DRAM_dataOut` in, `DRAM_dataIn`/`memAV` out). It owns a single-port 2^WIDTH x WIDTH data RAM and serves up to NCORES cores one access at a time under round-robin arbitration. It also provides a write-only host load port for preloading image data.

## Interface
- `WIDTH`, 8: data and address width; RAM depth is 2^WIDTH.
- `NCORES`, 4: number of core request ports, 1..8.
- `Clk` in 1: clock; all state changes on the rising edge.
- `Rst` in 1: synchronous, active-high reset.
- `memREAD` in NCORES: per-core read request, level, held until served.
- `memWRITE` in NCORES: per-core write request, level, held until served.
- `coreAddr` in NCORES*WIDTH: per-core address; core k occupies bits [k*WIDTH +: WIDTH].
- `coreWData` in NCORES*WIDTH: per-core write data, same packing.
- `rdData` out WIDTH: read data, broadcast to all cores.
- `memAV` out NCORES: one-cycle per-core completion strobe.
- `extWE` in 1: host write request.
- `extAddr` in WIDTH: host address.
- `extData` in WIDTH: host write data.
- `extAck` out 1: one-cycle strobe when the host write is committed.
- `busy` out 1: high in every state except IDLE.
- `protoErr` out 1: sticky flag; set when any core drives read and write together.
- `accCount` out 16: completed core accesses. Present only with `DRAM_ARB_STATS_EN`.

## Operation
- FSM states are IDLE, SERVE and DONE.
- **IDLE**
  - If `extWE` is high, the RAM is written immediately (host has priority), `extAck` is high on the next cycle, and the FSM stays in IDLE.
  - Otherwise, if any core is eligible, the grant goes to the first eligible core searching upward from `rrPtr` with wrap-around. The FSM latches core index, op, address and data, then moves to SERVE.
- **Eligibility:** core k is eligible when (`memREAD[k]` | `memWRITE[k]`) & !`needDrop[k]`.
- **SERVE**
  - Write: RAM[addr] <= data.
  - Read: synchronous RAM read is issued.
  - Next state is DONE.
- **DONE**
  - `memAV[k]` is high for exactly this cycle.
  - On a read, `rdData` has been loaded with the RAM output at the SERVE->DONE edge.
  - `rrPtr` <= (k+1) mod NCORES; `needDrop[k]` is set; next state is IDLE.
- **needDrop[k]** clears on any cycle where both `memREAD[k]` and `memWRITE[k]` are low. A request still held after `memAV` is therefore never served twice.
- **Read and write asserted together:** the write is performed and `protoErr` is set. `protoErr` is cleared only by `Rst`.
- **Hold rules**
  - `rdData` holds its value until the next read completes.
  - Write completions do not change `rdData`.
  - The latched address and data are used for the whole access, so a core changing inputs mid-access has no effect.
- Addresses are WIDTH bits with no wrap logic beyond natural truncation.
- RAM contents are not reset.

## Timing
- **Reset values:** `memAV`=0, `extAck`=0, `rdData`=0, `busy`=0, `protoErr`=0, `accCount`=0, `rrPtr`=0, `needDrop`=0, state IDLE.
- **Latency:** a request sampled in IDLE at edge t gives SERVE in cycle t+1 and `memAV` high in cycle t+2. `rdData` is valid in that same cycle and stays valid afterwards.
- **Throughput:** 3 cycles per core access with no gap between grants of different cores; 1 cycle per host write.
- **Host priority:** `extWE` held high starves the cores; this is intended for preload only.
- **Host write during SERVE/DONE:** not accepted. `extAck` stays low until the write is taken in IDLE.
- **Rst mid-access:** the access is abandoned with no `memAV`. A write still in SERVE at the reset edge is not committed.
- **Simultaneous requests:** exactly one core is granted per IDLE cycle; the others wait. The worst-case wait for a core is (NCORES-1)*3 cycles plus host activity.

## Configuration
- `DRAM_ARB_STATS_EN` defined:
  - The `accCount` port exists.
  - It increments in each DONE cycle, saturating at 16'hFFFF.
  - It is reset to 0 by `Rst`.
- Not defined: the port and its counter are absent. All other behaviour is identical.

## Test plan
- **Host preload then read:**
  - Stimulus: host writes 0x5A to addr 0x10 (`extAck` expected the next cycle); core 0 then holds `memREAD` with addr 0x10.
  - Response: `memAV[0]` high 2 cycles after sampling, `rdData`=0x5A, `accCount`=1.
- **Four-core contention:**
  - Stimulus: cores 0-3 all request in the same cycle.
  - Response: grants come in order 0,1,2,3 with `memAV` strobes 3 cycles apart; each held request is served exactly once until it is dropped and re-raised.
- **Write then read-back:**
  - Stimulus: core 2 writes 0xC3 to addr 0xFF, then core 1 reads 0xFF.
  - Response: `rdData`=0xC3. During core 2's write, `rdData` keeps its previous value.
- **Protocol error:**
  - Stimulus: core 3 asserts read and write together with data 0x77 at addr 0x01.
  - Response: the write commits, `protoErr`=1 and stays set; a later read of 0x01 returns 0x77.
- **Reset mid-access:**
  - Stimulus: `Rst` is asserted while the FSM is in SERVE for a core 1 write of 0x99 to addr 0x20.
  - Response: no `memAV`, all outputs return to reset values, and RAM[0x20] is unchanged.
- **Host preemption:**
  - Stimulus: `extWE` is high for 3 cycles while core 0 is requesting.
  - Response: three `extAck` pulses, then core 0 is granted in the first IDLE cycle after `extWE` falls.
